// File: rtl/mpu_bus_master.sv
// Host-side initiator for the ChronoCube MPU bus: turns read/write burst commands
// into setup/strobe/hold strobe sequences and returns read data as one-cycle pulses.
module mpu_bus_master #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int LEN_WIDTH     = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [1:0]            cmd_be,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  busy,
  output logic                  _mpu_en,
  output logic                  _mpu_rd,
  output logic                  _mpu_wr,
  output logic [1:0]            _mpu_be,
  output logic [ADDR_WIDTH-1:0] mpu_addr,
  output logic [DATA_WIDTH-1:0] mpu_data_out,
  input  logic [DATA_WIDTH-1:0] mpu_data_in
);

  localparam int MaxSH     = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MaxCycles = (STROBE_CYCLES > MaxSH) ? STROBE_CYCLES : MaxSH;
  localparam int CntWidth  = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  state_e                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  write_q;
  logic [LEN_WIDTH-1:0]  beats_q;
  logic [1:0]            be_q;
  logic                  en_q;
  logic                  rd_q;
  logic                  wr_q;
  logic [1:0]            mpu_be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic                  rlast_q;

  // Phase counter counts down from (phase length - 1); a phase ends when it reaches zero.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      beats_q  <= '0;
      be_q     <= '0;
      en_q     <= 1'b1;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      mpu_be_q <= 2'b11;
      addr_q   <= '0;
      dout_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            write_q <= cmd_write;
            addr_q  <= cmd_addr;
            beats_q <= cmd_len;
            be_q    <= cmd_be;
            if (cmd_write) begin
              state_q <= WDATA;
            end else begin
              state_q  <= SETUP;
              en_q     <= 1'b0;
              mpu_be_q <= ~cmd_be;
              cnt_q    <= CntWidth'(SETUP_CYCLES - 1);
            end
          end
        end
        WDATA: begin
          if (wdata_valid) begin
            dout_q   <= wdata;
            state_q  <= SETUP;
            en_q     <= 1'b0;
            mpu_be_q <= ~be_q;
            cnt_q    <= CntWidth'(SETUP_CYCLES - 1);
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            state_q <= STROBE;
            cnt_q   <= CntWidth'(STROBE_CYCLES - 1);
            if (write_q) wr_q <= 1'b0;
            else         rd_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STROBE: begin
          if (cnt_q == '0) begin
            state_q <= HOLD;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            cnt_q   <= CntWidth'(HOLD_CYCLES - 1);
            if (!write_q) begin
              rdata_q  <= mpu_data_in;
              rvalid_q <= 1'b1;
              rlast_q  <= (beats_q == '0);
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            if (beats_q != '0) begin
              beats_q <= beats_q - 1'b1;
              addr_q  <= addr_q + 1'b1;
              if (write_q) begin
                state_q <= WDATA;
              end else begin
                state_q <= SETUP;
                cnt_q   <= CntWidth'(SETUP_CYCLES - 1);
              end
            end else begin
              state_q  <= IDLE;
              en_q     <= 1'b1;
              mpu_be_q <= 2'b11;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state_q == IDLE) && _reset;
  assign wdata_ready  = (state_q == WDATA);
  assign busy         = (state_q != IDLE);
  assign _mpu_en      = en_q;
  assign _mpu_rd      = rd_q;
  assign _mpu_wr      = wr_q;
  assign _mpu_be      = mpu_be_q;
  assign mpu_addr     = addr_q;
  assign mpu_data_out = dout_q;
  assign rdata        = rdata_q;
  assign rdata_valid  = rvalid_q;
  assign rdata_last   = rlast_q;

endmodule

// File: tb/tb_mpu_bus_master.sv
// Directed bench for mpu_bus_master: a target model answers reads, and scoreboards
// of expected read pulses and write strobes are checked by negedge monitors.
module tb_mpu_bus_master;

  logic        clk;
  logic        _reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [1:0]  cmd_be;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [15:0] wdata;
  logic        rdata_valid;
  logic [15:0] rdata;
  logic        rdata_last;
  logic        busy;
  logic        _mpu_en;
  logic        _mpu_rd;
  logic        _mpu_wr;
  logic [1:0]  _mpu_be;
  logic [15:0] mpu_addr;
  logic [15:0] mpu_data_out;
  logic [15:0] mpu_data_in;

  int checks = 0;
  int errors = 0;
  int rdPulses = 0;
  int wrPulses = 0;
  int rdRun = 0;
  int wrRun = 0;
  logic prevWr = 1'b1;

  logic [16:0] readQ[$];
  logic [33:0] writeQ[$];

  mpu_bus_master dut (
    .clk          (clk),
    ._reset       (_reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_be       (cmd_be),
    .wdata_valid  (wdata_valid),
    .wdata_ready  (wdata_ready),
    .wdata        (wdata),
    .rdata_valid  (rdata_valid),
    .rdata        (rdata),
    .rdata_last   (rdata_last),
    .busy         (busy),
    ._mpu_en      (_mpu_en),
    ._mpu_rd      (_mpu_rd),
    ._mpu_wr      (_mpu_wr),
    ._mpu_be      (_mpu_be),
    .mpu_addr     (mpu_addr),
    .mpu_data_out (mpu_data_out),
    .mpu_data_in  (mpu_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] targetData(input logic [15:0] a);
    return (a == 16'h0102) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  assign mpu_data_in = targetData(mpu_addr);

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offers a command from a posedge+1 point and returns at posedge+1 of the cycle after acceptance.
  task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [3:0] l, input logic [1:0] b);
    logic got;
    got = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_be    = b;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    checkOutput("cmd_accept", 64'(got), 64'(1));
  endtask

  // Bus protocol and scoreboard monitors, sampled on the falling edge.
  always @(negedge clk) begin
    logic [16:0] expR;
    logic [33:0] expW;
    if (!_reset) begin
      rdRun  = 0;
      wrRun  = 0;
      prevWr = 1'b1;
    end else begin
      checkOutput("rd_wr_exclusive", 64'(_mpu_rd | _mpu_wr), 64'(1));
      if (rdata_valid) begin
        rdPulses++;
        checkOutput("rdata_pending", 64'(readQ.size() != 0), 64'(1));
        if (readQ.size() != 0) begin
          expR = readQ.pop_front();
          checkOutput("rdata_beat", 64'({rdata_last, rdata}), 64'(expR));
        end
      end
      if (!_mpu_wr && prevWr) begin
        wrPulses++;
        checkOutput("write_pending", 64'(writeQ.size() != 0), 64'(1));
        if (writeQ.size() != 0) begin
          expW = writeQ.pop_front();
          checkOutput("write_beat", 64'({mpu_addr, mpu_data_out, _mpu_be}), 64'(expW));
        end
      end
      prevWr = _mpu_wr;
      if (!_mpu_rd) rdRun++;
      else if (rdRun != 0) begin
        checkOutput("rd_width", 64'(rdRun), 64'(2));
        rdRun = 0;
      end
      if (!_mpu_wr) wrRun++;
      else if (wrRun != 0) begin
        checkOutput("wr_width", 64'(wrRun), 64'(2));
        wrRun = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulsesBefore;
    int enBad;
    int stallBad;
    logic [15:0] pulseMask;
    logic [15:0] burstAddr;

    _reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    cmd_be = '0;
    wdata_valid = 1'b0;
    wdata = '0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_en", 64'(_mpu_en), 64'(1));
    checkOutput("rst_rd", 64'(_mpu_rd), 64'(1));
    checkOutput("rst_wr", 64'(_mpu_wr), 64'(1));
    checkOutput("rst_be", 64'(_mpu_be), 64'(2'b11));
    checkOutput("rst_addr", 64'(mpu_addr), 64'(0));
    checkOutput("rst_dout", 64'(mpu_data_out), 64'(0));
    checkOutput("rst_rdata", 64'({rdata_valid, rdata_last, rdata}), 64'(0));
    checkOutput("rst_wready", 64'(wdata_ready), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    #1 _reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    @(posedge clk);
    #1;

    // Single read at 0x0102
    $display("[TB] single read");
    readQ.push_back({1'b1, 16'hBEEF});
    applyStimulus(1'b0, 16'h0102, 4'd0, 2'b11);
    @(negedge clk);
    checkOutput("rd1_c1_en", 64'(_mpu_en), 64'(0));
    checkOutput("rd1_c1_rd", 64'(_mpu_rd), 64'(1));
    checkOutput("rd1_c1_addr", 64'(mpu_addr), 64'(16'h0102));
    checkOutput("rd1_c1_be", 64'(_mpu_be), 64'(2'b00));
    checkOutput("rd1_c1_busy", 64'({busy, cmd_ready}), 64'(2'b10));
    @(negedge clk);
    checkOutput("rd1_c2_rd", 64'(_mpu_rd), 64'(0));
    @(negedge clk);
    checkOutput("rd1_c3_rd", 64'(_mpu_rd), 64'(0));
    @(negedge clk);
    checkOutput("rd1_c4_rd", 64'(_mpu_rd), 64'(1));
    checkOutput("rd1_c4_valid", 64'({rdata_valid, rdata_last, rdata}), 64'({2'b11, 16'hBEEF}));
    checkOutput("rd1_c4_en", 64'(_mpu_en), 64'(0));
    @(negedge clk);
    checkOutput("rd1_c5_idle", 64'({busy, cmd_ready, _mpu_en, rdata_valid}), 64'(4'b0110));
    checkOutput("rd1_c5_be", 64'(_mpu_be), 64'(2'b11));
    @(posedge clk);
    #1;

    // Single write at 0x0200, be 01
    $display("[TB] single write");
    wdata = 16'h1234;
    wdata_valid = 1'b1;
    writeQ.push_back({16'h0200, 16'h1234, 2'b10});
    applyStimulus(1'b1, 16'h0200, 4'd0, 2'b01);
    @(negedge clk);
    checkOutput("wr1_c1_wready", 64'({wdata_ready, _mpu_en, busy}), 64'(3'b111));
    @(posedge clk);
    #1 wdata_valid = 1'b0;
    @(negedge clk);
    checkOutput("wr1_c2_bus", 64'({_mpu_en, _mpu_be, mpu_addr, mpu_data_out}), 64'({1'b0, 2'b10, 16'h0200, 16'h1234}));
    checkOutput("wr1_c2_wready", 64'(wdata_ready), 64'(0));
    @(negedge clk);
    checkOutput("wr1_c3_wr", 64'(_mpu_wr), 64'(0));
    @(negedge clk);
    checkOutput("wr1_c4_wr", 64'(_mpu_wr), 64'(0));
    @(negedge clk);
    checkOutput("wr1_c5_hold", 64'({_mpu_wr, _mpu_en, mpu_addr, mpu_data_out}), 64'({2'b10, 16'h0200, 16'h1234}));
    @(negedge clk);
    checkOutput("wr1_c6_idle", 64'({busy, _mpu_en}), 64'(2'b01));
    @(posedge clk);
    #1;

    // Wrapping read burst from 0xFFFE, four beats
    $display("[TB] wrapping read burst");
    burstAddr = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      readQ.push_back({(i == 3) ? 1'b1 : 1'b0, targetData(burstAddr)});
      burstAddr = burstAddr + 16'd1;
    end
    pulsesBefore = rdPulses;
    enBad = 0;
    pulseMask = '0;
    applyStimulus(1'b0, 16'hFFFE, 4'd3, 2'b11);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (_mpu_en !== 1'b0) enBad++;
      pulseMask[c-1] = rdata_valid;
      if (c == 13) checkOutput("burst_addr_wrap", 64'(mpu_addr), 64'(16'h0001));
      @(posedge clk);
      #1;
    end
    checkOutput("burst_en_low", 64'(enBad), 64'(0));
    checkOutput("burst_pulse_spacing", 64'(pulseMask), 64'(16'b1000_1000_1000_1000));
    checkOutput("burst_pulse_count", 64'(rdPulses - pulsesBefore), 64'(4));
    @(negedge clk);
    checkOutput("burst_idle", 64'({busy, _mpu_en}), 64'(2'b01));
    @(posedge clk);
    #1;

    // Two-beat write with a 10-cycle data stall before beat 2
    $display("[TB] write stall");
    wdata = 16'hAAAA;
    wdata_valid = 1'b1;
    writeQ.push_back({16'h0300, 16'hAAAA, 2'b00});
    writeQ.push_back({16'h0301, 16'h5555, 2'b00});
    pulsesBefore = wrPulses;
    stallBad = 0;
    applyStimulus(1'b1, 16'h0300, 4'd1, 2'b11);
    for (int c = 1; c <= 21; c++) begin
      if (c == 2) wdata_valid = 1'b0;
      if (c == 16) begin
        wdata = 16'h5555;
        wdata_valid = 1'b1;
      end
      if (c == 17) wdata_valid = 1'b0;
      @(negedge clk);
      if (c >= 6 && c <= 15 && ({_mpu_en, _mpu_wr, _mpu_rd, wdata_ready} !== 4'b0111)) stallBad++;
      if (c == 21) checkOutput("stall_idle", 64'({busy, _mpu_en}), 64'(2'b01));
      @(posedge clk);
      #1;
    end
    checkOutput("stall_hold", 64'(stallBad), 64'(0));
    checkOutput("stall_wr_pulses", 64'(wrPulses - pulsesBefore), 64'(2));

    // Reset during the strobe of beat 2 of a read burst
    $display("[TB] reset mid-strobe");
    readQ.push_back({1'b0, targetData(16'h0400)});
    pulsesBefore = rdPulses;
    applyStimulus(1'b0, 16'h0400, 4'd2, 2'b11);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rst_mid_rd_low", 64'(_mpu_rd), 64'(0));
    _reset = 1'b0;
    #1;
    checkOutput("rst_mid_strobes", 64'({_mpu_en, _mpu_rd, _mpu_wr, _mpu_be}), 64'(5'b11111));
    checkOutput("rst_mid_state", 64'({busy, rdata_valid, mpu_addr}), 64'(0));
    repeat (2) @(negedge clk);
    #1 _reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_ready", 64'({cmd_ready, busy}), 64'(2'b10));
    repeat (6) @(negedge clk);
    checkOutput("rst_mid_pulses", 64'(rdPulses - pulsesBefore), 64'(1));
    @(posedge clk);
    #1;

    // Back-to-back read then write with cmd_valid held
    $display("[TB] back-to-back");
    readQ.push_back({1'b1, targetData(16'h0500)});
    writeQ.push_back({16'h0600, 16'h0F0F, 2'b01});
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 16'h0500;
    cmd_len = 4'd0;
    cmd_be = 2'b11;
    wdata = 16'h0F0F;
    wdata_valid = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      if (c == 1) begin
        cmd_write = 1'b1;
        cmd_addr = 16'h0600;
        cmd_be = 2'b10;
      end
      if (c == 6) cmd_valid = 1'b0;
      if (c == 7) wdata_valid = 1'b0;
      @(negedge clk);
      if (c == 0) checkOutput("b2b_c0_ready", 64'(cmd_ready), 64'(1));
      if (c == 2) checkOutput("b2b_c2_ready", 64'(cmd_ready), 64'(0));
      if (c == 4) checkOutput("b2b_c4_rvalid", 64'(rdata_valid), 64'(1));
      if (c == 5) checkOutput("b2b_c5_idle", 64'({cmd_ready, busy}), 64'(2'b10));
      if (c == 6) checkOutput("b2b_c6_wdata", 64'({wdata_ready, busy}), 64'(2'b11));
      if (c == 8) checkOutput("b2b_c8_wr", 64'({_mpu_wr, _mpu_rd, mpu_addr}), 64'({2'b01, 16'h0600}));
      if (c == 11) checkOutput("b2b_c11_idle", 64'({busy, cmd_ready}), 64'(2'b01));
      @(posedge clk);
      #1;
    end

    checkOutput("readq_drained", 64'(readQ.size()), 64'(0));
    checkOutput("writeq_drained", 64'(writeQ.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
